// File: rtl/divider.sv
// rtl/divider.sv - 32/16 signed restoring divider; optional quotient saturation via DIVIDER_OVF_CHECK_EN
module divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        dz,
    output logic        ovf
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] div_q, div_d;
    logic        neg_q, neg_d;
    logic        sign_a_q, sign_a_d;
    logic [15:0] quotient_q, quotient_d;
    logic [15:0] remainder_q, remainder_d;
    logic        dz_q, dz_d;
    logic        ovf_q, ovf_d;

    logic [31:0] a_mag;
    logic [15:0] b_mag;
    logic [16:0] trial;
    logic        fits;
    logic [15:0] q_fix;
    logic [15:0] r_fix;
    logic        ovf_fix;

    always_comb begin
        a_mag = a[31] ? (32'd0 - a) : a;
        b_mag = b[15] ? (16'd0 - b) : b;
        // Remainder stays below the divisor, so the shifted trial value never exceeds 16 bits of payload
        trial = {rem_q, dvd_q[31]};
        fits  = (trial >= {1'b0, div_q});
        r_fix = sign_a_q ? (16'd0 - rem_q) : rem_q;
`ifdef DIVIDER_OVF_CHECK_EN
        ovf_fix = neg_q ? (dvd_q > 32'h0000_8000) : (dvd_q > 32'h0000_7FFF);
        if (ovf_fix) begin
            q_fix = neg_q ? 16'h8000 : 16'h7FFF;
        end else begin
            q_fix = neg_q ? (16'd0 - dvd_q[15:0]) : dvd_q[15:0];
        end
`else
        ovf_fix = 1'b0;
        q_fix   = neg_q ? (16'd0 - dvd_q[15:0]) : dvd_q[15:0];
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        rem_d       = rem_q;
        div_d       = div_q;
        neg_d       = neg_q;
        sign_a_d    = sign_a_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dz_d        = dz_q;
        ovf_d       = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d    = a_mag;
                    rem_d    = 16'd0;
                    div_d    = b_mag;
                    neg_d    = a[31] ^ b[15];
                    sign_a_d = a[31];
                    cnt_d    = 5'd0;
                    if (b == 16'd0) begin
                        // Divide-by-zero results are written now so they are valid in the DONE cycle
                        quotient_d  = 16'hFFFF;
                        remainder_d = a[15:0];
                        dz_d        = 1'b1;
                        ovf_d       = 1'b0;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (fits) begin
                    rem_d = trial[15:0] - div_q;
                end else begin
                    rem_d = trial[15:0];
                end
                dvd_d = {dvd_q[30:0], fits};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                quotient_d  = q_fix;
                remainder_d = r_fix;
                dz_d        = 1'b0;
                ovf_d       = ovf_fix;
                state_d     = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 5'd0;
            dvd_q       <= 32'd0;
            rem_q       <= 16'd0;
            div_q       <= 16'd0;
            neg_q       <= 1'b0;
            sign_a_q    <= 1'b0;
            quotient_q  <= 16'd0;
            remainder_q <= 16'd0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            rem_q       <= rem_d;
            div_q       <= div_d;
            neg_q       <= neg_d;
            sign_a_q    <= sign_a_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dz_q        <= dz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dz        = dz_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - directed self-checking bench for divider
module tb_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = 32'd0;
    logic [15:0] b = 16'd0;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        dz;
    logic        ovf;

    int tests = 0;
    int fails = 0;
    int lat;

    divider dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_div(input logic [31:0] aa, input logic [15:0] bb, output int l);
        @(negedge clk);
        a = aa;
        b = bb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        l = 1;
        while (!done && l < 100) begin
            @(negedge clk);
            l++;
        end
    endtask

    initial begin
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_q", {16'd0, quotient}, 32'd0);
        chk("rst_r", {16'd0, remainder}, 32'd0);
        chk("rst_dz", {31'd0, dz}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div(32'd100, 16'd7, lat);
        chk("p7_lat", lat, 34);
        chk("p7_q", {16'd0, quotient}, 32'd14);
        chk("p7_r", {16'd0, remainder}, 32'd2);
        chk("p7_dz", {31'd0, dz}, 32'd0);
        chk("p7_ovf", {31'd0, ovf}, 32'd0);

        run_div(-32'sd100, 16'd7, lat);
        chk("n7_lat", lat, 34);
        chk("n7_q", {16'd0, quotient}, 32'h0000_FFF2);
        chk("n7_r", {16'd0, remainder}, 32'h0000_FFFE);

        run_div(32'd100, 16'hFFF9, lat);
        chk("pn7_q", {16'd0, quotient}, 32'h0000_FFF2);
        chk("pn7_r", {16'd0, remainder}, 32'd2);

        run_div(32'd100, 16'd0, lat);
        chk("dz_lat", lat, 1);
        chk("dz_busy", {31'd0, busy}, 32'd1);
        chk("dz_flag", {31'd0, dz}, 32'd1);
        chk("dz_q", {16'd0, quotient}, 32'h0000_FFFF);
        chk("dz_r", {16'd0, remainder}, 32'h0000_0064);
        chk("dz_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        chk("dz_busy_after", {31'd0, busy}, 32'd0);
        chk("dz_hold", {31'd0, dz}, 32'd1);

        run_div(32'h0001_0000, 16'd1, lat);
        chk("big_lat", lat, 34);
        chk("big_dz", {31'd0, dz}, 32'd0);
        chk("big_r", {16'd0, remainder}, 32'd0);
`ifdef DIVIDER_OVF_CHECK_EN
        chk("big_ovf", {31'd0, ovf}, 32'd1);
        chk("big_q", {16'd0, quotient}, 32'h0000_7FFF);
`else
        chk("big_ovf", {31'd0, ovf}, 32'd0);
        chk("big_q", {16'd0, quotient}, 32'h0000_0000);
`endif

        run_div(32'h8000_0000, 16'hFFFF, lat);
        chk("min_lat", lat, 34);
        chk("min_r", {16'd0, remainder}, 32'd0);
`ifdef DIVIDER_OVF_CHECK_EN
        chk("min_ovf", {31'd0, ovf}, 32'd1);
        chk("min_q", {16'd0, quotient}, 32'h0000_7FFF);
`else
        chk("min_ovf", {31'd0, ovf}, 32'd0);
        chk("min_q", {16'd0, quotient}, 32'h0000_0000);
`endif

        // start held high; operand change mid-division must not leak in
        @(negedge clk);
        a = 32'd1000;
        b = 16'd10;
        start = 1'b1;
        @(negedge clk);
        lat = 1;
        while (!done && lat < 100) begin
            if (lat == 5) a = 32'd7;
            @(negedge clk);
            lat++;
        end
        chk("hold_lat", lat, 34);
        chk("hold_q", {16'd0, quotient}, 32'd100);
        chk("hold_r", {16'd0, remainder}, 32'd0);
        @(negedge clk);
        chk("hold_idle_n35", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("hold_busy_n36", {31'd0, busy}, 32'd1);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("hold2_lat", lat, 34);
        chk("hold2_q", {16'd0, quotient}, 32'd0);
        chk("hold2_r", {16'd0, remainder}, 32'd7);

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        a = 32'd12345;
        b = 16'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_q", {16'd0, quotient}, 32'd0);
        chk("arst_r", {16'd0, remainder}, 32'd0);
        chk("arst_dz", {31'd0, dz}, 32'd0);
        chk("arst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        a = -32'sd1000;
        b = 16'd33;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("post_rst_lat", lat, 34);
        chk("post_rst_q", {16'd0, quotient}, 32'h0000_FFE2);
        chk("post_rst_r", {16'd0, remainder}, 32'h0000_FFF6);
        chk("post_rst_dz", {31'd0, dz}, 32'd0);
        @(negedge clk);
        chk("post_rst_done_pulse", {31'd0, done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
